// File: rtl/mux_8_1_scan_controller_if.sv
// Bundle between the scan controller, the 8:1 mux it steers, and the result consumer.
// Handshake: Scan_Data_Out is held stable while Scan_Valid_Out is high; the transfer
// completes on a rising edge where Scan_Valid_Out and Scan_Ready_In are both 1.
interface mux_8_1_scan_controller_if;
  logic       Start_In;
  logic [7:0] Channel_Mask_In;
  logic       MUX_Result_Data_In;
  logic       MUX_Enable_Out;
  logic [2:0] MUX_Select_Out;
  logic [7:0] Scan_Data_Out;
  logic       Scan_Valid_Out;
  logic       Scan_Ready_In;
  logic       Busy_Out;

  modport master (
    input  Start_In, Channel_Mask_In, MUX_Result_Data_In, Scan_Ready_In,
    output MUX_Enable_Out, MUX_Select_Out, Scan_Data_Out, Scan_Valid_Out, Busy_Out
  );

  modport slave (
    output Start_In, Channel_Mask_In, MUX_Result_Data_In, Scan_Ready_In,
    input  MUX_Enable_Out, MUX_Select_Out, Scan_Data_Out, Scan_Valid_Out, Busy_Out
  );
endinterface

// File: rtl/mux_8_1_scan_controller.sv
// Walks an 8:1 mux through channels 0..7, dwells on each enabled channel,
// samples the mux output on the last dwell cycle and hands the 8-bit word out.
module mux_8_1_scan_controller #(
  parameter int DWELL_CYCLES = 2
) (
  input  logic                          Clock_In,
  input  logic                          Reset_In,
  mux_8_1_scan_controller_if.master     bus,
  output logic [1:0]                    State_Dbg_Out
);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
    $error("DWELL_CYCLES must be in 1..255");
  end

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    data_q, data_d;

  logic          chan_on;
  logic          chan_last;
  logic          cap_bit;

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      ch_q    <= 3'd0;
      dwell_q <= '0;
      mask_q  <= 8'h00;
      cap_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
    end
  end

  // A masked-off channel always lasts one cycle; an enabled one ends when the countdown hits 1.
  assign chan_on   = mask_q[ch_q];
  assign chan_last = !chan_on || (dwell_q == CW'(1));
  // Only a clean 1 counts as set, so X/Z from an unsettled mux store 0.
  assign cap_bit   = chan_on && (bus.MUX_Result_Data_In === 1'b1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start_In) begin
          mask_d  = bus.Channel_Mask_In;
          cap_d   = 8'h00;
          ch_d    = 3'd0;
          dwell_d = DWELL_LD;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chan_last) begin
          cap_d[ch_q] = cap_bit;
          if (ch_q == 3'd7) begin
            data_d  = cap_d;
            state_d = S_VALID;
          end else begin
            ch_d    = ch_q + 3'd1;
            dwell_d = DWELL_LD;
          end
        end else begin
          dwell_d = dwell_q - CW'(1);
        end
      end
      S_VALID: begin
        if (bus.Scan_Ready_In) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.MUX_Enable_Out = (state_q == S_SCAN) && chan_on;
    bus.MUX_Select_Out = 3'd0;
    if (state_q == S_SCAN)  bus.MUX_Select_Out = ch_q;
    if (state_q == S_VALID) bus.MUX_Select_Out = 3'd7;
  end

  assign bus.Scan_Data_Out  = data_q;
  assign bus.Scan_Valid_Out = (state_q == S_VALID);
  assign bus.Busy_Out       = (state_q != S_IDLE);
  assign State_Dbg_Out      = state_q;

endmodule

// File: tb/tb_mux_8_1_scan_controller.sv
// Directed bench for the 8:1 mux scan controller with a behavioural mux model.
module tb_mux_8_1_scan_controller;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;

  logic [7:0] mux_word;
  logic       x_ch2;

  int vectors;
  int miscompares;

  mux_8_1_scan_controller_if bus_if ();

  mux_8_1_scan_controller #(.DWELL_CYCLES(2)) dut (
    .Clock_In      (clk),
    .Reset_In      (rst),
    .bus           (bus_if.master),
    .State_Dbg_Out (state_dbg)
  );

  // Mux model: combinational, output 0 when disabled, optional X on channel 2.
  assign bus_if.MUX_Result_Data_In =
    !bus_if.MUX_Enable_Out ? 1'b0 :
    (x_ch2 && bus_if.MUX_Select_Out == 3'd2) ? 1'bx :
    mux_word[bus_if.MUX_Select_Out];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_data);
    check({tag, " busy"},   {7'd0, bus_if.Busy_Out},       8'd0);
    check({tag, " valid"},  {7'd0, bus_if.Scan_Valid_Out}, 8'd0);
    check({tag, " enable"}, {7'd0, bus_if.MUX_Enable_Out}, 8'd0);
    check({tag, " select"}, {5'd0, bus_if.MUX_Select_Out}, 8'd0);
    check({tag, " data"},   bus_if.Scan_Data_Out,          exp_data);
    check({tag, " state"},  {6'd0, state_dbg},             8'd0);
  endtask

  task automatic check_valid(input string tag, input logic [7:0] exp_data);
    check({tag, " valid"},  {7'd0, bus_if.Scan_Valid_Out}, 8'd1);
    check({tag, " data"},   bus_if.Scan_Data_Out,          exp_data);
    check({tag, " select"}, {5'd0, bus_if.MUX_Select_Out}, 8'd7);
    check({tag, " enable"}, {7'd0, bus_if.MUX_Enable_Out}, 8'd0);
    check({tag, " busy"},   {7'd0, bus_if.Busy_Out},       8'd1);
  endtask

  // Start a scan with all channels enabled and run to the VALID cycle (E0+16).
  task automatic full_scan(input logic [7:0] word);
    mux_word = word;
    bus_if.Channel_Mask_In = 8'hFF;
    bus_if.Start_In = 1'b1;
    tick();
    bus_if.Start_In = 1'b0;
    for (int i = 1; i <= 16; i++) tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mux_word = 8'h00;
    x_ch2 = 1'b0;
    bus_if.Start_In = 1'b0;
    bus_if.Channel_Mask_In = 8'h00;
    bus_if.Scan_Ready_In = 1'b0;

    // Reset applied between edges takes effect immediately.
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle("reset", 8'h00);
    #9 rst = 1'b0;
    tick();
    check_idle("post_reset", 8'h00);

    // Full scan: mask FF, data A5, ready high.
    bus_if.Scan_Ready_In = 1'b1;
    mux_word = 8'hA5;
    bus_if.Channel_Mask_In = 8'hFF;
    bus_if.Start_In = 1'b1;
    tick();
    bus_if.Start_In = 1'b0;
    check("full e0 busy",   {7'd0, bus_if.Busy_Out},       8'd1);
    check("full e0 enable", {7'd0, bus_if.MUX_Enable_Out}, 8'd1);
    check("full e0 select", {5'd0, bus_if.MUX_Select_Out}, 8'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("full e%0d select", i), {5'd0, bus_if.MUX_Select_Out}, 8'(i / 2));
      check($sformatf("full e%0d enable", i), {7'd0, bus_if.MUX_Enable_Out}, 8'd1);
      check($sformatf("full e%0d valid", i),  {7'd0, bus_if.Scan_Valid_Out}, 8'd0);
    end
    tick();
    check_valid("full e16", 8'hA5);
    tick();
    check_idle("full e17", 8'hA5);

    // Partial mask 0F with data FF: channels 4..7 take one disabled cycle each.
    mux_word = 8'hFF;
    bus_if.Channel_Mask_In = 8'h0F;
    bus_if.Start_In = 1'b1;
    tick();
    bus_if.Start_In = 1'b0;
    for (int i = 1; i < 12; i++) begin
      tick();
      check($sformatf("part e%0d select", i), {5'd0, bus_if.MUX_Select_Out},
            (i < 8) ? 8'(i / 2) : 8'(4 + i - 8));
      check($sformatf("part e%0d enable", i), {7'd0, bus_if.MUX_Enable_Out},
            (i < 8) ? 8'd1 : 8'd0);
      check($sformatf("part e%0d valid", i),  {7'd0, bus_if.Scan_Valid_Out}, 8'd0);
    end
    tick();
    check_valid("part e12", 8'h0F);
    tick();
    check_idle("part e13", 8'h0F);

    // Empty mask: eight disabled cycles then VALID with 00.
    bus_if.Channel_Mask_In = 8'h00;
    bus_if.Start_In = 1'b1;
    tick();
    bus_if.Start_In = 1'b0;
    check("empty e0 enable", {7'd0, bus_if.MUX_Enable_Out}, 8'd0);
    check("empty e0 busy",   {7'd0, bus_if.Busy_Out},       8'd1);
    for (int i = 1; i < 8; i++) tick();
    check("empty e7 valid",  {7'd0, bus_if.Scan_Valid_Out}, 8'd0);
    check("empty e7 select", {5'd0, bus_if.MUX_Select_Out}, 8'd7);
    tick();
    check_valid("empty e8", 8'h00);
    tick();
    check_idle("empty e9", 8'h00);

    // Backpressure: ready low for 5 VALID cycles with a start pulse inside.
    bus_if.Scan_Ready_In = 1'b0;
    full_scan(8'h3C);
    check_valid("bp first", 8'h3C);
    for (int i = 0; i < 5; i++) begin
      bus_if.Start_In = (i == 2);
      tick();
      check_valid($sformatf("bp hold%0d", i), 8'h3C);
    end
    bus_if.Start_In = 1'b0;
    bus_if.Scan_Ready_In = 1'b1;
    tick();
    check_idle("bp release", 8'h3C);
    tick();
    check_idle("bp no_requeue", 8'h3C);

    // Reset while channel 3 is selected aborts the scan and clears the result.
    mux_word = 8'h5A;
    bus_if.Channel_Mask_In = 8'hFF;
    bus_if.Start_In = 1'b1;
    tick();
    bus_if.Start_In = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    check("mid select3", {5'd0, bus_if.MUX_Select_Out}, 8'd3);
    #2 rst = 1'b1;
    #1;
    check_idle("mid reset", 8'h00);
    rst = 1'b0;
    full_scan(8'h5A);
    check_valid("mid rescan", 8'h5A);
    tick();
    check_idle("mid rescan done", 8'h5A);

    // Back-to-back with start held high and X on channel 2.
    x_ch2 = 1'b1;
    mux_word = 8'hFF;
    bus_if.Channel_Mask_In = 8'hFF;
    bus_if.Start_In = 1'b1;
    for (int i = 0; i <= 16; i++) tick();
    check_valid("b2b first", 8'hFB);
    tick();
    check_idle("b2b handshake", 8'hFB);
    tick();
    check("b2b restart busy",   {7'd0, bus_if.Busy_Out},       8'd1);
    check("b2b restart enable", {7'd0, bus_if.MUX_Enable_Out}, 8'd1);
    check("b2b restart select", {5'd0, bus_if.MUX_Select_Out}, 8'd0);
    for (int i = 1; i <= 16; i++) tick();
    check_valid("b2b second", 8'hFB);
    bus_if.Start_In = 1'b0;
    tick();
    check_idle("b2b end", 8'hFB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_8_1_scan_controller.md
# mux_8_1_scan_controller

Sequencer that sits directly upstream of the 8:1 multiplexer and consumes its output. On a start request it walks the mux `Select_In` through channels 0..7, holds each selected channel for a programmable dwell time and samples `MUX_Result_Data_Out` on the last dwell cycle. It then presents the eight sampled bits as one parallel word on a valid/ready handshake. The mux itself stays purely combinational; all timing lives here.

## Interface
- `DWELL_CYCLES`, default 2: clock cycles each enabled channel stays selected. Legal range is 1..255; values outside it are a configuration error.
- `Clock_In`  input  1  single clock; rising edge active.
- `Reset_In`  input  1  asynchronous, active-high reset.
- `Start_In`  input  1  scan request; sampled only in IDLE.
- `Channel_Mask_In`  input  8  bit n = 1 means scan channel n; captured on the accepted start.
- `MUX_Result_Data_In`  input  1  driven by the mux `MUX_Result_Data_Out`.
- `MUX_Enable_Out`  output  1  drives the mux `Enable_In`.
- `MUX_Select_Out`  output  3  drives the mux `Select_In`.
- `Scan_Data_Out`  output  8  bit n = sampled value of channel n.
- `Scan_Valid_Out`  output  1  `Scan_Data_Out` holds a new result.
- `Scan_Ready_In`  input  1  consumer accepts the result.
- `Busy_Out`  output  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, SCAN and VALID.
- IDLE:
  - `MUX_Enable_Out`=0 and `MUX_Select_Out`=0.
  - `Start_In`=1 at a rising edge captures `Channel_Mask_In`, clears the capture register, sets channel index 0 and moves to SCAN.
- SCAN, with channel index `ch` (0..7):
  - `MUX_Select_Out`=`ch` throughout.
  - Mask bit `ch` = 1: `MUX_Enable_Out`=1 for exactly `DWELL_CYCLES` cycles. At the edge ending the last dwell cycle, capture bit `ch` = 1 if `MUX_Result_Data_In` === 1, otherwise 0 (X and Z store 0).
  - Mask bit `ch` = 0: the channel takes exactly 1 cycle with `MUX_Enable_Out`=0, and capture bit `ch` = 0.
  - At the edge that ends channel 7, the completed capture word is copied to `Scan_Data_Out` and the state moves to VALID. Otherwise `ch` increments and the dwell counter reloads.
- VALID:
  - `Scan_Valid_Out`=1, `MUX_Enable_Out`=0, `MUX_Select_Out`=7.
  - `Scan_Data_Out` is stable.
  - A rising edge with `Scan_Ready_In`=1 completes the handshake and returns to IDLE.
  - `Start_In` is ignored in VALID and in SCAN; no request queuing.
- `Scan_Data_Out` changes only on the SCAN→VALID edge and holds its last result in IDLE.
- Mask `8'h00`: 8 single cycles with enable low, then VALID with data `8'h00`.
- Dwell counter width is `$clog2(DWELL_CYCLES+1)`. The counter counts down, with no wrap beyond reload.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; `MUX_Enable_Out`=0, `MUX_Select_Out`=0, `Scan_Data_Out`=`8'h00`, `Scan_Valid_Out`=0, `Busy_Out`=0.
  - Captured mask and capture register are cleared.
- Reset mid-SCAN or mid-VALID aborts the scan; the partial result is discarded.
- Start accepted at edge E0:
  - `Busy_Out`=1, `MUX_Enable_Out`=1 if mask[0], and `MUX_Select_Out`=0, all visible after E0.
- Latency:
  - With k enabled channels, `Scan_Valid_Out` rises after edge E0 + k·`DWELL_CYCLES` + (8−k).
  - All channels enabled with `DWELL_CYCLES`=2: valid after E0+16.
- Handshake:
  - If `Scan_Ready_In` is high in the first VALID cycle, valid lasts exactly 1 cycle.
  - After the handshake edge, IDLE is entered. A new start can be accepted at the next edge, never at the handshake edge itself.
- Select changes and enable changes occur only on rising edges, so the mux output has a full cycle to settle before sampling.

## Test plan
- **Reset values:** assert `Reset_In` asynchronously between edges → all outputs reach their reset values immediately; `Busy_Out`=0.
- **Full scan:** `DWELL_CYCLES`=2, mask `8'hFF`, a mux model fed data `8'hA5`, start, `Scan_Ready_In`=1 → `MUX_Select_Out` steps 0..7 every 2 cycles; `Scan_Valid_Out` is high at E0+16 for 1 cycle with `Scan_Data_Out`=`8'hA5`.
- **Partial mask:** mask `8'h0F`, data `8'hFF` → channels 4–7 take 1 cycle each with enable low; valid at E0+12; `Scan_Data_Out`=`8'h0F`.
- **Backpressure:** hold `Scan_Ready_In`=0 for 5 cycles and pulse `Start_In` during VALID → valid and data stay stable; the start is ignored; on ready the block returns to IDLE with no second scan.
- **Reset mid-scan:** assert reset while `MUX_Select_Out`=3 → immediate IDLE; `Scan_Data_Out` keeps `8'h00`; a following start runs a clean full scan.
- **Back-to-back and X input:** hold `Start_In` high continuously; the mux drives X on channel 2 → scans restart one cycle after each handshake; bit 2 reads 0.
